dkong_input_ctrl: RTL
=====================

# dkong_input_ctrl

Player-input conditioner between the HPS I/O block and `dkong_top`. It decodes PS/2 key events and OR-merges both joysticks, then applies the orientation remap. It produces registered, active-low control lines for `dkong_top` (`I_U1`…`I_C1`). The coin line is a timed pulse generated by a small FSM, not a level.

## Interface

Parameters:
- `COIN_PULSE`, default 1228800: coin-low duration in clocks (50 ms at 24.576 MHz); minimum 1.
- `COIN_GAP`, default 1228800: minimum coin-high time after a pulse, in clocks; minimum 1.
- `CW`, default 24: width of the coin timing counter; must hold max(`COIN_PULSE`, `COIN_GAP`).

Ports:
- `I_CLK_24576M`  in  1  system clock; single clock domain.
- `I_RESETn`  in  1  reset; one clock, asynchronous, active-low.
- `I_PS2_KEY`  in  11  [10] toggles once per event; [9] 1=press, 0=release; [8:0] scan code, where [8] is the extended flag.
- `I_JOY0`, `I_JOY1`  in  16 each  joysticks, active-high; bit 0=R, 1=L, 2=D, 3=U, 4=jump, 5=start1, 6=start2.
- `I_NO_ROTATE`  in  1  1=horizontal monitor; applies the direction remap.
- `I_KEY_CLR`  in  1  synchronous clear of all latched key states; driven during ROM download.
- `O_U1`, `O_D1`, `O_L1`, `O_R1`, `O_J1`  out  1 each  player 1, active-low.
- `O_U2`, `O_D2`, `O_L2`, `O_R2`, `O_J2`  out  1 each  player 2, active-low.
- `O_S1`, `O_S2`  out  1 each  start buttons, active-low.
- `O_C1`  out  1  coin, active-low pulse.

## Operation

Key event detection:
- Register `tog_q` holds the previous `I_PS2_KEY[10]`.
- Flag `armed` resets to 0. The first clock after reset loads `tog_q` and sets `armed`; no event is decoded on that clock.
- An event occurs on a clock where `armed` is 1 and `I_PS2_KEY[10] != tog_q`. On that clock the matching key latch takes `I_PS2_KEY[9]`.

Key map:
- These match with [8] = don't-care: 0x75 up, 0x72 down, 0x6B left, 0x74 right.
- These require [8]=0:
  - 0x29 and 0x14: fire1.
  - 0x05 and 0x16: start1.
  - 0x06 and 0x1E: start2.
  - 0x2E and 0x36: coin.
  - 0x2D up2, 0x2B down2, 0x23 left2, 0x34 right2, 0x1C fire2.
- Any other code is ignored.
- Keys sharing a latch (for example space and ctrl) share one latch; the last event wins.
- `I_KEY_CLR`=1 clears every key latch to 0. If an event falls on the same clock, the clear wins and `tog_q` is still updated.

Merge:
- Stage-1 register: `joy = I_JOY0 | I_JOY1`.
- Each logical input is its key latch OR the joy bit.
- Player 2 directions and jump use the player-2 keys OR the same joy bits.

Rotation:
- `I_NO_ROTATE`=1: up=left source, down=right source, left=down source, right=up source.
- `I_NO_ROTATE`=0: straight mapping.
- Fire, start and coin are not remapped.

Start and coin requests:
- `O_S1` is the inverse of (start1 key OR joy[5]); `O_S2` is the inverse of (start2 key OR joy[6]).
- `req` = start1 | start2 | coin key. `req_rise` is its 0→1 edge against the previous cycle's `req`.

Coin FSM, states IDLE, PULSE, GAP:
- IDLE: on `req_rise` or `pending`, load `cnt` with `COIN_PULSE-1`, clear `pending`, go to PULSE.
- PULSE: `O_C1`=0. Decrement `cnt`. At `cnt`=0, load `COIN_GAP-1` and go to GAP.
- GAP: `O_C1`=1. Decrement `cnt`. At `cnt`=0, go to IDLE.
- A `req_rise` during PULSE or GAP sets `pending`, which holds one request. Further rises while `pending` is set are dropped.

## Timing

- Reset values: all outputs 1 (inactive), FSM IDLE, `cnt`=0, `pending`=0, key latches 0, `armed`=0, `tog_q`=0, stage-1 registers 0.
- Direction, fire and start latency is 2 clocks:
  - A key event decoded at edge N is visible on the outputs after edge N+1.
  - A `I_JOY*` change present before edge N is visible after edge N+1.
- Coin latency: a `req` edge registered at edge N moves the FSM to PULSE at edge N+1. `O_C1` is registered off the FSM state and goes low after edge N+2.
- Pulse length: `O_C1` is low for exactly `COIN_PULSE` clocks.
- Repeat spacing: a pending request starts its PULSE exactly `COIN_GAP`+1 clocks after the previous pulse ends (the extra clock is IDLE).
- Reset asserted mid-pulse: `O_C1` returns to 1 asynchronously and the pending request is discarded.
- `I_NO_ROTATE` toggling mid-press: the new mapping takes effect on the next output register update; there is no glitch filtering.

## Test plan

- Reset release with `I_PS2_KEY[10]`=1 held and no toggle: no latch changes, and all outputs remain 1 for at least 10 clocks.
- Key event 0x75 press, then release, with `I_NO_ROTATE`=0: `O_U1` goes 0 two clocks after the press event and returns to 1 two clocks after the release. The extended form 0x175 behaves the same.
- `I_NO_ROTATE`=1 and `I_JOY0`=0x0008 (up): `O_R1`=0 and `O_U1`=1 after 2 clocks. With `I_JOY1`=0x0001 added, `O_D1`=0 as well.
- With `COIN_PULSE`=4, `COIN_GAP`=3, press start1 twice in quick succession:
  - `O_S1` tracks the key.
  - `O_C1` is low for 4 clocks, high for 4 clocks, then low for 4 clocks.
  - A third rise during the GAP while a request is already pending is dropped.
- Press coin (0x2E), then assert `I_KEY_CLR` on the same clock as a release event of a different key: all latches clear, and `req` stays 0 after the clear.
- Assert `I_RESETn`=0 on the second clock of PULSE: `O_C1`=1 immediately. After release, no pulse occurs without a new `req_rise`.

Source files
------------

// File: rtl/dkong_input_ctrl.sv
// dkong_input_ctrl: conditions PS/2 key events and both joysticks into the
// registered, active-low control lines of dkong_top, including the timed
// coin pulse.
module dkong_input_ctrl #(
    parameter int unsigned COIN_PULSE = 1228800,
    parameter int unsigned COIN_GAP   = 1228800,
    parameter int unsigned CW         = 24
) (
    input  logic        I_CLK_24576M,
    input  logic        I_RESETn,
    input  logic [10:0] I_PS2_KEY,
    input  logic [15:0] I_JOY0,
    input  logic [15:0] I_JOY1,
    input  logic        I_NO_ROTATE,
    input  logic        I_KEY_CLR,
    output logic        O_U1,
    output logic        O_D1,
    output logic        O_L1,
    output logic        O_R1,
    output logic        O_J1,
    output logic        O_U2,
    output logic        O_D2,
    output logic        O_L2,
    output logic        O_R2,
    output logic        O_J2,
    output logic        O_S1,
    output logic        O_S2,
    output logic        O_C1
);

    // Key latch slots
    localparam int unsigned K_UP = 0, K_DN = 1, K_LT = 2, K_RT = 3, K_F1 = 4;
    localparam int unsigned K_S1 = 5, K_S2 = 6, K_CN = 7;
    localparam int unsigned K_U2 = 8, K_D2 = 9, K_L2 = 10, K_R2 = 11, K_F2 = 12;
    localparam int unsigned NK = 13;

    typedef enum logic [1:0] {IDLE, PULSE, GAP} coin_state_e;

    logic          tog_q;
    logic          armed_q;
    logic [NK-1:0] keys_q;
    logic [NK-1:0] keys_d;
    logic [NK-1:0] hit;
    logic [6:0]    joy_q;
    logic [11:0]   out_q;
    logic [11:0]   out_d;
    logic          key_event;

    coin_state_e   state_q;
    logic [CW-1:0] cnt_q;
    logic          pending_q;
    logic          req_q;
    logic          c1_q;
    logic          req;
    logic          req_rise;

    logic up1, dn1, lt1, rt1, f1, up2, dn2, lt2, rt2, f2, s1, s2, coin;
    logic unused_joy_hi;

    assign unused_joy_hi = ^{I_JOY0[15:7], I_JOY1[15:7]};
    assign key_event     = armed_q && (I_PS2_KEY[10] != tog_q);

    // Scan-code decode into a one-hot latch select
    always_comb begin
        hit = '0;
        case (I_PS2_KEY[7:0])
            8'h75:   hit[K_UP] = 1'b1;
            8'h72:   hit[K_DN] = 1'b1;
            8'h6B:   hit[K_LT] = 1'b1;
            8'h74:   hit[K_RT] = 1'b1;
            default: ;
        endcase
        if (!I_PS2_KEY[8]) begin
            case (I_PS2_KEY[7:0])
                8'h29, 8'h14: hit[K_F1] = 1'b1;
                8'h05, 8'h16: hit[K_S1] = 1'b1;
                8'h06, 8'h1E: hit[K_S2] = 1'b1;
                8'h2E, 8'h36: hit[K_CN] = 1'b1;
                8'h2D:        hit[K_U2] = 1'b1;
                8'h2B:        hit[K_D2] = 1'b1;
                8'h23:        hit[K_L2] = 1'b1;
                8'h34:        hit[K_R2] = 1'b1;
                8'h1C:        hit[K_F2] = 1'b1;
                default:      ;
            endcase
        end
    end

    // Next key-latch state; the clear overrides a coincident event
    always_comb begin
        keys_d = keys_q;
        if (I_KEY_CLR) begin
            keys_d = '0;
        end else if (key_event) begin
            keys_d = (keys_q & ~hit) | (hit & {NK{I_PS2_KEY[9]}});
        end
    end

    // Stage 1: toggle tracking, key latches and merged joystick
    always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            tog_q   <= 1'b0;
            armed_q <= 1'b0;
            keys_q  <= '0;
            joy_q   <= '0;
        end else begin
            tog_q   <= I_PS2_KEY[10];
            armed_q <= 1'b1;
            keys_q  <= keys_d;
            joy_q   <= I_JOY0[6:0] | I_JOY1[6:0];
        end
    end

    assign up1  = keys_q[K_UP] | joy_q[3];
    assign dn1  = keys_q[K_DN] | joy_q[2];
    assign lt1  = keys_q[K_LT] | joy_q[1];
    assign rt1  = keys_q[K_RT] | joy_q[0];
    assign f1   = keys_q[K_F1] | joy_q[4];
    assign up2  = keys_q[K_U2] | joy_q[3];
    assign dn2  = keys_q[K_D2] | joy_q[2];
    assign lt2  = keys_q[K_L2] | joy_q[1];
    assign rt2  = keys_q[K_R2] | joy_q[0];
    assign f2   = keys_q[K_F2] | joy_q[4];
    assign s1   = keys_q[K_S1] | joy_q[5];
    assign s2   = keys_q[K_S2] | joy_q[6];
    assign coin = keys_q[K_CN];

    assign req      = s1 | s2 | coin;
    assign req_rise = req & ~req_q;

    // Orientation remap and inversion to active-low
    always_comb begin
        out_d = ~{I_NO_ROTATE ? lt1 : up1,
                  I_NO_ROTATE ? rt1 : dn1,
                  I_NO_ROTATE ? dn1 : lt1,
                  I_NO_ROTATE ? up1 : rt1,
                  f1,
                  I_NO_ROTATE ? lt2 : up2,
                  I_NO_ROTATE ? rt2 : dn2,
                  I_NO_ROTATE ? dn2 : lt2,
                  I_NO_ROTATE ? up2 : rt2,
                  f2,
                  s1,
                  s2};
    end

    // Stage 2: registered player outputs
    always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            out_q <= '1;
        end else begin
            out_q <= out_d;
        end
    end

    // Coin pulse FSM with a one-deep pending request; O_C1 lags the state by one clock
    always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            req_q     <= 1'b0;
            c1_q      <= 1'b1;
        end else begin
            req_q <= req;
            c1_q  <= (state_q != PULSE);
            case (state_q)
                IDLE: begin
                    if (req_rise || pending_q) begin
                        cnt_q     <= CW'(COIN_PULSE - 1);
                        pending_q <= 1'b0;
                        state_q   <= PULSE;
                    end
                end
                PULSE: begin
                    if (req_rise) pending_q <= 1'b1;
                    if (cnt_q == '0) begin
                        cnt_q   <= CW'(COIN_GAP - 1);
                        state_q <= GAP;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                GAP: begin
                    if (req_rise) pending_q <= 1'b1;
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign {O_U1, O_D1, O_L1, O_R1, O_J1, O_U2, O_D2, O_L2, O_R2, O_J2, O_S1, O_S2} = out_q;
    assign O_C1 = c1_q;

endmodule
